// File: rtl/imem_loader_if.sv
// Boot-loader bus: byte stream in, imem write port out, plus core reset and load status.
// master = host/stream side, slave = imem_loader.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  start;
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;
   logic                  core_rst;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic [15:0]           loaded_words;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata,
      input  core_rst, busy, done, error, loaded_words
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata,
      output core_rst, busy, done, error, loaded_words
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length-prefixed little-endian byte stream into imem words,
// holding the core in reset until the image has been written.
module imem_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic          clk,
   input  logic          rst,
   imem_loader_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_DONE,
      S_ERR
   } state_t;

   state_t                r_state;
   logic [15:0]           r_len;
   logic [1:0]            r_byte_idx;
   logic [23:0]           r_buf;
   logic [ADDR_WIDTH-1:0] r_word_ptr;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [15:0]           r_loaded;

   state_t                w_state_next;
   logic [15:0]           w_len_next;
   logic [1:0]            w_byte_idx_next;
   logic [23:0]           w_buf_next;
   logic [ADDR_WIDTH-1:0] w_word_ptr_next;
   logic                  w_we_next;
   logic [ADDR_WIDTH-1:0] w_addr_next;
   logic [31:0]           w_wdata_next;
   logic [15:0]           w_loaded_next;

   logic                  w_in_ready;
   logic                  w_xfer;
   logic [15:0]           w_len_full;
   logic [15:0]           w_loaded_inc;
   logic [2:0]            w_lane_we;

   assign w_in_ready   = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA);
   assign w_xfer       = bus.in_valid & w_in_ready;
   assign w_len_full   = {bus.in_data, r_len[7:0]};
   assign w_loaded_inc = r_loaded + 16'd1;

   // Lanes 0..2 are buffered; lane 3 goes straight into the write word.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         assign w_lane_we[gi] = w_xfer && (r_state == S_DATA) && (r_byte_idx == 2'(gi));
         assign w_buf_next[gi*8 +: 8] = w_lane_we[gi] ? bus.in_data : r_buf[gi*8 +: 8];
      end
   endgenerate

   always_comb begin
      w_state_next    = r_state;
      w_len_next      = r_len;
      w_byte_idx_next = r_byte_idx;
      w_word_ptr_next = r_word_ptr;
      w_we_next       = 1'b0;
      w_addr_next     = r_addr;
      w_wdata_next    = r_wdata;
      w_loaded_next   = r_loaded;

      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (bus.start) begin
               w_state_next  = S_LEN_LO;
               w_loaded_next = 16'd0;
            end
         end
         S_LEN_LO: begin
            if (w_xfer) begin
               w_len_next[7:0] = bus.in_data;
               w_state_next    = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (w_xfer) begin
               w_len_next[15:8] = bus.in_data;
               if (w_len_full == 16'd0) begin
                  w_state_next = S_DONE;
               end else if (32'(w_len_full) > 32'(DEPTH)) begin
                  w_state_next = S_ERR;
               end else begin
                  w_state_next    = S_DATA;
                  w_byte_idx_next = 2'd0;
                  w_word_ptr_next = '0;
               end
            end
         end
         S_DATA: begin
            if (w_xfer) begin
               w_byte_idx_next = r_byte_idx + 2'd1;
               if (r_byte_idx == 2'd3) begin
                  w_we_next       = 1'b1;
                  w_addr_next     = r_word_ptr;
                  w_wdata_next    = {bus.in_data, r_buf};
                  w_word_ptr_next = r_word_ptr + 1'b1;
                  w_loaded_next   = w_loaded_inc;
                  if (w_loaded_inc == r_len) begin
                     w_state_next = S_DONE;
                  end
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_len      <= '0;
         r_byte_idx <= '0;
         r_buf      <= '0;
         r_word_ptr <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_loaded   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_len      <= w_len_next;
         r_byte_idx <= w_byte_idx_next;
         r_buf      <= w_buf_next;
         r_word_ptr <= w_word_ptr_next;
         r_we       <= w_we_next;
         r_addr     <= w_addr_next;
         r_wdata    <= w_wdata_next;
         r_loaded   <= w_loaded_next;
      end
   end

   // Status is decoded from state so done/error are exclusive by construction.
   assign bus.in_ready     = w_in_ready;
   assign bus.busy         = w_in_ready;
   assign bus.done         = (r_state == S_DONE);
   assign bus.error        = (r_state == S_ERR);
   assign bus.core_rst     = (r_state != S_DONE);
   assign bus.imem_we      = r_we;
   assign bus.imem_addr    = r_addr;
   assign bus.imem_wdata   = r_wdata;
   assign bus.loaded_words = r_loaded;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: random images streamed with varied throttling,
// expected writes queued at stimulus time and checked by an independent monitor.
module tb_imem_loader;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_WIDTH(AW)) bus ();
   imem_loader #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst_n), .bus(bus));

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] img [DEPTH];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n) begin
         check("done_error_exclusive", 32'(bus.done & bus.error), 32'd0);
         if (bus.imem_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", 32'(bus.imem_addr), 32'hFFFF_FFFF);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               $display("[TB] write addr=%0d data=0x%08h (expected addr=%0d data=0x%08h)",
                        bus.imem_addr, bus.imem_wdata, e.addr, e.data);
               check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
               check("wr_data", bus.imem_wdata, e.data);
               check("wr_count", 32'(bus.loaded_words), 32'(e.addr) + 32'd1);
            end
         end
      end
   end

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int w;
      repeat (gap) begin
         bus.in_valid = 1'b0;
         bus.in_data  = 8'($urandom);
         @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      w = 0;
      while (!bus.in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!bus.in_ready) begin
         check("handshake_timeout", 32'(bus.in_ready), 32'd1);
      end else begin
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_core_rst"}, 32'(bus.core_rst), 32'd1);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_error"}, 32'(bus.error), 32'd0);
      check({tag, "_loaded"}, 32'(bus.loaded_words), 32'd0);
      check({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
      check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
   endtask

   // mode 0: back-to-back, 1: alternate-cycle valid with a 7-cycle gap in word 1, 2: random gaps.
   task automatic run_load(input int n, input int len, input int mode);
      logic [15:0] lenv;
      int          g;
      bit          ok;
      wr_t         e;
      lenv = 16'(len);
      pulse_start();
      check("start_busy", 32'(bus.busy), 32'd1);
      check("start_core_rst", 32'(bus.core_rst), 32'd1);
      check("start_clears_status", 32'({bus.done, bus.error}), 32'd0);
      send_byte(lenv[7:0], (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2)));
      send_byte(lenv[15:8], (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2)));
      ok = (len >= 1) && (len <= DEPTH);
      if (ok) begin
         for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
               if (mode == 0)      g = 0;
               else if (mode == 1) g = 1 + ((i == 1 && b == 2) ? 7 : 0);
               else                g = int'($urandom_range(0, 3));
               if (mode == 2 && i == 1 && b == 0) pulse_start();
               if (b == 3) begin
                  e.addr = AW'(i);
                  e.data = img[i];
                  exp_q.push_back(e);
               end
               send_byte(8'(img[i] >> (8 * b)), g);
            end
         end
      end
      $display("[TB] load len=%0d mode=%0d: done=%0b error=%0b core_rst=%0b loaded=%0d",
               len, mode, bus.done, bus.error, bus.core_rst, bus.loaded_words);
      check("end_done", 32'(bus.done), 32'(len <= DEPTH));
      check("end_error", 32'(bus.error), 32'(len > DEPTH));
      check("end_core_rst", 32'(bus.core_rst), 32'(len > DEPTH));
      check("end_in_ready", 32'(bus.in_ready), 32'd0);
      check("end_busy", 32'(bus.busy), 32'd0);
      check("end_loaded", 32'(bus.loaded_words), ok ? 32'(len) : 32'd0);
      @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;

      // Idle with bytes offered: nothing consumed, core held in reset.
      bus.in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         bus.in_data = 8'($urandom);
         @(negedge clk);
         check("idle_core_rst", 32'(bus.core_rst), 32'd1);
         check("idle_in_ready", 32'(bus.in_ready), 32'd0);
         check("idle_done", 32'(bus.done), 32'd0);
      end
      bus.in_valid = 1'b0;

      img[0] = 32'h0050_0513;
      img[1] = 32'h00A0_0593;
      run_load(2, 2, 0);
      run_load(2, 2, 1);

      // Bytes offered in DONE are ignored.
      bus.in_valid = 1'b1;
      repeat (5) begin
         bus.in_data = 8'($urandom);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check("done_hold_loaded", 32'(bus.loaded_words), 32'd2);
      check("done_hold_done", 32'(bus.done), 32'd1);

      run_load(0, 0, 0);
      run_load(0, 17, 0);
      fill_random();
      run_load(1, 1, 0);

      // Asynchronous reset after two bytes of word 0.
      fill_random();
      pulse_start();
      send_byte(8'd2, 0);
      send_byte(8'd0, 0);
      send_byte(img[0][7:0], 0);
      send_byte(img[0][15:8], 0);
      #2 rst_n = 1'b0;
      #1 check_reset_values("midload_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_load(2, 2, 0);

      fill_random();
      run_load(DEPTH, DEPTH, 2);

      for (int k = 0; k < 8; k++) begin
         int n;
         fill_random();
         n = int'($urandom_range(1, DEPTH));
         run_load(n, n, int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the single-cycle RISC-V core's instruction memory. It receives a byte stream over a valid/ready interface, assembles the bytes into little-endian 32-bit instructions, and writes them to consecutive imem word addresses.
- It holds the datapath in reset until the image is fully loaded, then releases the core so it fetches from PC 0.
- It sits between the host/UART byte source and the imem write port. It drives the datapath's active-high `rst`.

Parameters:
- ADDR_WIDTH, 10, imem word-address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that begins a load
- in_valid  in  1  byte-stream valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  imem write strobe, one cycle per word
- imem_addr  out  ADDR_WIDTH  word index of the write
- imem_wdata  out  32  instruction word
- core_rst  out  1  active-high reset to the datapath
- busy  out  1  a load is in progress
- done  out  1  last load completed successfully
- error  out  1  last load rejected because its length exceeded DEPTH
- loaded_words  out  16  words written in the current or last load

Behaviour:
- Handshake: a byte transfers when in_valid & in_ready are both high at a rising clk edge. in_ready is a function of state only and never depends on in_valid.
- Reset (rst=0, asynchronous):
  - state=IDLE, core_rst=1, in_ready=0, imem_we=0.
  - imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, loaded_words=0.
  - The byte index, length register and word buffer are all cleared.
- Stream format: LEN_LO byte, LEN_HI byte, then 4*N instruction bytes. N={LEN_HI,LEN_LO}. Within each word, bytes arrive LSB first.
- States:
  - IDLE: in_ready=0. On start, go to LEN_LO; also clear done/error/loaded_words and set busy=1, core_rst=1.
  - LEN_LO: in_ready=1. On transfer, latch the low length byte and go to LEN_HI.
  - LEN_HI: in_ready=1. On transfer, latch the high byte, then:
    - N==0: go to DONE.
    - N>DEPTH: go to ERR.
    - otherwise: go to DATA with byte_idx=0 and word_ptr=0.
  - DATA: in_ready=1. Each transfer shifts the byte into buffer lane byte_idx, then byte_idx increments mod 4.
    - On the transfer with byte_idx==3, the next cycle shows imem_we=1, imem_addr=word_ptr, imem_wdata={in_data, buf[23:0]}, all registered.
    - In that same edge word_ptr and loaded_words increment.
    - If the incremented count equals N, go to DONE; otherwise stay in DATA.
    - Bytes for the next word may be accepted while imem_we is high, so back-to-back bytes sustain 1 byte/cycle.
  - DONE: in_ready=0, busy=0, done=1, core_rst=0. start re-enters LEN_LO and reasserts core_rst=1 in the same edge.
  - ERR: in_ready=0, busy=0, error=1, core_rst stays 1. start re-enters LEN_LO.
- Write timing: imem_we is high for exactly one cycle per word and never while in IDLE/LEN_LO/LEN_HI. The write of the final word occurs in the cycle where done first reads 1; imem must accept writes during that cycle.
- Boundaries:
  - start asserted in LEN_LO/LEN_HI/DATA is ignored; no restart.
  - in_valid low mid-word pauses the load; byte_idx and buffer are held indefinitely.
  - N==DEPTH is legal. The last write goes to address DEPTH-1, and word_ptr is not required to wrap.
  - Asynchronous reset mid-load aborts immediately. Outputs return to reset values; imem contents already written are left as-is.
  - Bytes presented while in_ready=0 are not consumed.
- Status outputs: done and error are mutually exclusive. busy = state in {LEN_LO, LEN_HI, DATA}.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release, no start for 10 cycles -> core_rst=1, in_ready=0, imem_we never 1, done=0.
- 2-word load at 1 byte/cycle: start; stream 02 00, 13 05 50 00, 93 05 A0 00 -> two one-cycle strobes with addr0=0x00500513 and addr1=0x00A00593; done=1, core_rst=0, loaded_words=2 one cycle after the last byte.
- Throttled stream: the same image with in_valid toggling every other cycle and a 7-cycle gap inside word 1 -> identical writes and data, no extra strobes.
- Zero length: start; stream 00 00 -> DONE two transfers after start, no imem_we, core_rst=0.
- Oversize length with ADDR_WIDTH=4: stream 11 00 (N=17) -> ERR, error=1, core_rst=1, in_ready=0; a following start plus a valid N=1 image loads correctly and clears error.
- Reset mid-load: assert rst after byte 2 of word 0 -> all outputs take reset values asynchronously; the next full load writes from addr 0 with correct data.
